// File: rtl/diffeq_mul_arbiter_pkg.sv
// Shared constants for the diffeq multiplier arbiter: FSM encodings,
// default operand width and the saturation limits at that width.
package diffeq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEF_WIDTH = 16;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/diffeq_mul_arbiter_seq_mult.sv
// Iterative unsigned shift-add multiplier core. A start pulse loads the
// operand magnitudes; one multiplier bit is consumed per cycle for WIDTH
// cycles. done is high during the final step, so product holds the full
// result from the following cycle until the next start.
import diffeq_pkg::*;

module seq_mult #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   count;
  logic               run;

  assign done    = run && (count == LAST);
  assign product = acc;

  // Load on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      count  <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        run   <= 1'b0;
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/diffeq_mul_arbiter.sv
// Round-robin arbiter sharing one iterative signed multiplier among N_REQ
// requesters. Operand signs are stripped before the unsigned core and
// re-applied in DONE, where overflow is detected and the output formatted.
// Optional build macro DIFFEQ_MUL_SAT_EN: saturate result on overflow
// instead of returning the truncated low WIDTH bits.
import diffeq_pkg::*;

module diffeq_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       result,
  output logic                   result_valid,
  output logic [ID_W-1:0]        result_id,
  output logic                   ovf
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               neg;
  logic [WIDTH-1:0]   res_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   a_win, b_win, mag_a, mag_b;
  logic               start, mul_done;
  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH:0]     prod_hi;
  logic               fits;
  logic [WIDTH-1:0]   fmt_res;
  logic               fmt_ovf;
  int                 idx;

  // Round-robin search: first set req bit at or above ptr, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign a_win = op_a[int'(win)*WIDTH +: WIDTH];
  assign b_win = op_b[int'(win)*WIDTH +: WIDTH];
  // -(-2^(W-1)) wraps back to 2^(W-1), which is exactly the right unsigned magnitude.
  assign mag_a = a_win[WIDTH-1] ? -a_win : a_win;
  assign mag_b = b_win[WIDTH-1] ? -b_win : b_win;
  assign start = (state == IDLE) && found;

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (mag_a),
    .b       (mag_b),
    .done    (mul_done),
    .product (prod_u)
  );

  // Sign fix and range check on the full 2*WIDTH product.
  always_comb begin
    prod_s  = neg ? -prod_u : prod_u;
    prod_hi = prod_s[2*WIDTH-1:WIDTH-1];
    fits    = (&prod_hi) | ~(|prod_hi);
    fmt_ovf = ~fits;
`ifdef DIFFEQ_MUL_SAT_EN
    fmt_res = fits ? prod_s[WIDTH-1:0] : (prod_s[2*WIDTH-1] ? SMIN : SMAX);
`else
    fmt_res = prod_s[WIDTH-1:0];
`endif
  end

  // Control FSM: arbitrate in IDLE, wait for the core in BUSY, publish in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      result_id <= '0;
      neg       <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt       <= N_REQ'(1) << win;
          result_id <= win;
          neg       <= a_win[WIDTH-1] ^ b_win[WIDTH-1];
          ptr       <= (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
          state     <= BUSY;
        end
        BUSY: if (mul_done) state <= DONE;
        DONE: begin
          gnt   <= '0;
          res_q <= fmt_res;
          ovf_q <= fmt_ovf;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // DONE shows the freshly formatted product; afterwards the captured copy holds.
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign result       = result_valid ? fmt_res : res_q;
  assign ovf          = result_valid ? fmt_ovf : ovf_q;

endmodule
